// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage with PC register, pending-branch
// capture, IF/ID pipeline register and a hold buffer for the SRAM data.
//
// Optional feature macro: IF_ADEL_EN
//   defined   : misaligned PCs suppress the SRAM read and raise if_adel in
//               step with the IF/ID register; the instruction is zeroed.
//   undefined : if_adel is tied low and fetch ignores pc_r[1:0].
//
// Ports
//   clk             in   clock, all state on posedge
//   rst             in   asynchronous active-low reset
//   stall[5:0]      in   stall[0] holds PC, stall[1] holds IF/ID register
//   br_bus[32:0]    in   {br_e, br_addr[31:0]} redirect from decode
//   inst_sram_en    out  SRAM read enable
//   inst_sram_wen   out  SRAM byte write enables (always 0)
//   inst_sram_addr  out  SRAM address (the PC register)
//   inst_sram_wdata out  SRAM write data (always 0)
//   inst_sram_rdata in   SRAM read data, one cycle after an enabled address
//   if_to_id_bus    out  registered {ce, pc[31:0]} for decode
//   inst_to_id      out  instruction matching if_to_id_bus
//   if_adel         out  registered fetch-address-error flag

module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic [32:0] if_to_id_bus,
  output logic [31:0] inst_to_id,
  output logic        if_adel
);

  localparam logic [31:0] PC_RESET = 32'hBFBF_FFFC;

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc_r;
  logic        ce_r;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic [31:0] next_pc;
  logic        buf_v;
  logic [31:0] inst_buf;
  logic        adel_r;

  // Only the two low stall bits concern this stage.
  logic unused_stall;
  assign unused_stall = &{1'b0, stall[5:2]};

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];

  // A live branch beats a branch remembered during a stall, which beats
  // sequential fetch.
  always_comb begin
    next_pc = pc_r + 32'd4;
    if (br_e)
      next_pc = br_addr;
    else if (pend_v)
      next_pc = pend_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r <= PC_RESET;
      ce_r <= 1'b0;
    end else if (!stall[0]) begin
      pc_r <= next_pc;
      ce_r <= 1'b1;
    end
  end

  // A branch arriving while the PC is frozen would otherwise be lost; keep
  // the most recent one until the PC moves again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v    <= 1'b0;
      pend_addr <= 32'h0;
    end else if (!stall[0]) begin
      pend_v <= 1'b0;
    end else if (br_e) begin
      pend_v    <= 1'b1;
      pend_addr <= br_addr;
    end
  end

  // IF/ID register: load when flowing, insert a bubble when only the PC is
  // stalled, hold when decode is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_to_id_bus <= 33'h0;
    end else if (!stall[1]) begin
      if (stall[0])
        if_to_id_bus <= 33'h0;
      else
        if_to_id_bus <= {ce_r, pc_r};
    end
  end

  // The SRAM re-reads the held PC during a decode stall, so the data that
  // belongs to the frozen IF/ID entry is captured on the first stalled edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_v    <= 1'b0;
      inst_buf <= 32'h0;
    end else if (!stall[1]) begin
      buf_v <= 1'b0;
    end else if (!buf_v) begin
      buf_v    <= 1'b1;
      inst_buf <= inst_sram_rdata;
    end
  end

`ifdef IF_ADEL_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adel_r <= 1'b0;
    end else if (!stall[1]) begin
      if (stall[0])
        adel_r <= 1'b0;
      else
        adel_r <= ce_r & (|pc_r[1:0]);
    end
  end

  assign inst_sram_en = ce_r & ~(|pc_r[1:0]);
`else
  assign adel_r       = 1'b0;
  assign inst_sram_en = ce_r;
`endif

  assign if_adel         = adel_r;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_r;
  assign inst_sram_wdata = 32'h0;

  always_comb begin
    inst_to_id = inst_sram_rdata;
    if (!if_to_id_bus[32] || adel_r)
      inst_to_id = 32'h0;
    else if (buf_v)
      inst_to_id = inst_buf;
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- directed bench for if_stage (default build, IF_ADEL_EN
// undefined). A small synchronous SRAM model answers reads one cycle after
// an enabled address; inputs change and outputs are sampled on negedge.

module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [32:0] if_to_id_bus;
  logic [31:0] inst_to_id;
  logic        if_adel;

  int checkCount = 0;
  int failCount  = 0;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .if_to_id_bus    (if_to_id_bus),
    .inst_to_id      (inst_to_id),
    .if_adel         (if_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: one fixed word at BFC00100, a simple pattern elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'hBFC0_0100)
      return 32'h2402_0005;
    return addr ^ 32'h1357_9BDF;
  endfunction

  initial inst_sram_rdata = 32'h0;
  always @(posedge clk)
    if (inst_sram_en)
      inst_sram_rdata <= memWord(inst_sram_addr);

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b0;
    stall  = 6'b000000;
    br_bus = 33'h0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_addr",  64'(inst_sram_addr), 64'h0000_0000_BFBF_FFFC);
    checkOutput("rst_en",    64'(inst_sram_en), 64'h0);
    checkOutput("rst_bus",   64'(if_to_id_bus), 64'h0);
    checkOutput("rst_inst",  64'(inst_to_id), 64'h0);
    checkOutput("rst_adel",  64'(if_adel), 64'h0);
    checkOutput("rst_wen",   64'(inst_sram_wen), 64'h0);
    checkOutput("rst_wdata", 64'(inst_sram_wdata), 64'h0);

    // Sequential fetch after reset release
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("seq_addr%0d", i), 64'(inst_sram_addr),
                  64'(32'hBFC0_0000 + 32'(4 * i)));
      checkOutput($sformatf("seq_en%0d", i), 64'(inst_sram_en), 64'h1);
    end
    checkOutput("seq_bus",  64'(if_to_id_bus), 64'({1'b1, 32'hBFC0_0008}));
    checkOutput("seq_inst", 64'(inst_to_id), 64'(memWord(32'hBFC0_0008)));

    // Asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    checkOutput("async_addr", 64'(inst_sram_addr), 64'h0000_0000_BFBF_FFFC);
    checkOutput("async_en",   64'(inst_sram_en), 64'h0);
    checkOutput("async_bus",  64'(if_to_id_bus), 64'h0);
    tick();
    rst = 1'b1;

    // Branch taken while PC is BFC00008; the delay slot still reaches decode
    repeat (3) tick();
    checkOutput("br_pre_addr", 64'(inst_sram_addr), 64'h0000_0000_BFC0_0008);
    br_bus = {1'b1, 32'hBFC0_0100};
    tick();
    br_bus = 33'h0;
    checkOutput("br_addr", 64'(inst_sram_addr), 64'h0000_0000_BFC0_0100);
    checkOutput("br_slot", 64'(if_to_id_bus), 64'({1'b1, 32'hBFC0_0008}));
    checkOutput("br_slot_inst", 64'(inst_to_id), 64'(memWord(32'hBFC0_0008)));
    tick();
    checkOutput("br_next_addr", 64'(inst_sram_addr), 64'h0000_0000_BFC0_0104);
    checkOutput("br_tgt_bus",   64'(if_to_id_bus), 64'({1'b1, 32'hBFC0_0100}));
    checkOutput("br_tgt_inst",  64'(inst_to_id), 64'h0000_0000_2402_0005);

    // Decode stall: held instruction survives while the SRAM re-reads
    stall = 6'b000011;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("hold_inst%0d", i), 64'(inst_to_id), 64'h0000_0000_2402_0005);
      checkOutput($sformatf("hold_bus%0d", i), 64'(if_to_id_bus),
                  64'({1'b1, 32'hBFC0_0100}));
      checkOutput($sformatf("hold_addr%0d", i), 64'(inst_sram_addr),
                  64'h0000_0000_BFC0_0104);
    end
    stall = 6'b000000;
    tick();
    checkOutput("hold_rel_bus",  64'(if_to_id_bus), 64'({1'b1, 32'hBFC0_0104}));
    checkOutput("hold_rel_inst", 64'(inst_to_id), 64'(memWord(32'hBFC0_0104)));
    checkOutput("hold_rel_addr", 64'(inst_sram_addr), 64'h0000_0000_BFC0_0108);

    // PC-only stall: bubbles into decode
    stall = 6'b000001;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("bub_bus%0d", i), 64'(if_to_id_bus), 64'h0);
      checkOutput($sformatf("bub_inst%0d", i), 64'(inst_to_id), 64'h0);
      checkOutput($sformatf("bub_addr%0d", i), 64'(inst_sram_addr),
                  64'h0000_0000_BFC0_0108);
    end
    stall = 6'b000000;
    tick();
    checkOutput("bub_rel_bus",  64'(if_to_id_bus), 64'({1'b1, 32'hBFC0_0108}));
    checkOutput("bub_rel_inst", 64'(inst_to_id), 64'(memWord(32'hBFC0_0108)));

    // Branch during stall is remembered and taken on release
    stall  = 6'b000001;
    br_bus = {1'b1, 32'hBFC0_0200};
    tick();
    br_bus = 33'h0;
    tick();
    checkOutput("pend_held_addr", 64'(inst_sram_addr), 64'h0000_0000_BFC0_010C);
    stall = 6'b000000;
    tick();
    checkOutput("pend_addr", 64'(inst_sram_addr), 64'h0000_0000_BFC0_0200);
    tick();
    checkOutput("pend_clr_addr", 64'(inst_sram_addr), 64'h0000_0000_BFC0_0204);

    // A second branch in the same stall overwrites the first
    stall  = 6'b000001;
    br_bus = {1'b1, 32'hBFC0_0300};
    tick();
    br_bus = {1'b1, 32'hBFC0_0400};
    tick();
    stall  = 6'b000000;
    br_bus = 33'h0;
    tick();
    checkOutput("pend_ovw_addr", 64'(inst_sram_addr), 64'h0000_0000_BFC0_0400);

    // Live branch on the release edge wins and the pending one is dropped
    stall  = 6'b000001;
    br_bus = {1'b1, 32'hBFC0_0500};
    tick();
    stall  = 6'b000000;
    br_bus = {1'b1, 32'hBFC0_0600};
    tick();
    br_bus = 33'h0;
    checkOutput("live_br_addr", 64'(inst_sram_addr), 64'h0000_0000_BFC0_0600);
    tick();
    checkOutput("live_br_next", 64'(inst_sram_addr), 64'h0000_0000_BFC0_0604);

    // Reset mid-stall with a pending branch and a held instruction
    stall  = 6'b000011;
    br_bus = {1'b1, 32'hBFC0_0700};
    tick();
    br_bus = 33'h0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_stall_addr", 64'(inst_sram_addr), 64'h0000_0000_BFBF_FFFC);
    checkOutput("rst_stall_inst", 64'(inst_to_id), 64'h0);
    tick();
    stall = 6'b000000;
    rst   = 1'b1;
    tick();
    checkOutput("rst_pend_addr", 64'(inst_sram_addr), 64'h0000_0000_BFC0_0000);
    tick();
    checkOutput("rst_buf_bus",  64'(if_to_id_bus), 64'({1'b1, 32'hBFC0_0000}));
    checkOutput("rst_buf_inst", 64'(inst_to_id), 64'(memWord(32'hBFC0_0000)));
    checkOutput("end_adel",     64'(if_adel), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
